// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] r_next, d_vec;
  logic [CW-1:0]    cnt;
  logic             borrow, a_msb, b_msb;
  logic             d, borrow_n, last;
  logic             busy_q, done_q, bout_q, ovf_q;
  logic [WIDTH-1:0] diff_q;

  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_n = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    // d is placed via a vector so WIDTH=1 needs no degenerate slice
    d_vec            = '0;
    d_vec[WIDTH-1]   = d;
    r_next           = (r_sh >> 1) | d_vec;
    last             = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          r_sh   <= r_next;
          borrow <= borrow_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff_q <= r_next;
            bout_q <= borrow_n;
            ovf_q  <= (a_msb != b_msb) & (d != a_msb);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table, handshake/reset sequences, random
// 8-bit operations and an exhaustive 4-bit sweep against an arithmetic reference.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain modular and signed integer arithmetic at width w.
  task automatic model(input int w, input int a, input int b,
                       output int d, output int bo, output int ov);
    int half, sa, sb, sd;
    half = 1 << (w - 1);
    d    = (a - b) & ((1 << w) - 1);
    bo   = (a < b) ? 1 : 0;
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    sd   = sa - sb;
    ov   = (sd < -half || sd >= half) ? 1 : 0;
  endtask

  task automatic run_op(input bit w4, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output int lat, output bit hs_ok);
    int guard;
    guard = 0;
    hs_ok = 1'b1;
    while (!(w4 ? bus4.ready : bus8.ready) && guard < 30) begin
      tick();
      guard++;
    end
    if (w4) begin
      bus4.start = 1'b1; bus4.a = a[3:0]; bus4.b = b[3:0];
    end else begin
      bus8.start = 1'b1; bus8.a = a; bus8.b = b;
    end
    tick();
    bus4.start = 1'b0; bus8.start = 1'b0;
    bus4.a = 4'($urandom); bus4.b = 4'($urandom);
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    if (w4 ? (!bus4.busy || bus4.ready) : (!bus8.busy || bus8.ready)) hs_ok = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (w4 ? bus4.done : bus8.done) begin
        lat = n;
        if (w4 ? bus4.busy : bus8.busy) hs_ok = 1'b0;
        break;
      end
      if (w4 ? (!bus4.busy || bus4.ready) : (!bus8.busy || bus8.ready)) hs_ok = 1'b0;
    end
    d  = w4 ? {4'b0, bus4.diff} : bus8.diff;
    bo = w4 ? bus4.bout : bus8.bout;
    ov = w4 ? bus4.ovf  : bus8.ovf;
  endtask

  initial begin
    logic [7:0] d, ra, rb;
    logic       bo, ov;
    int         lat, md, mbo, mov, ndone;
    bit         hs_ok;

    vecs[0] = '{8'd100, 8'd37, 8'd63,  1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd10, 8'd251, 1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd0,  8'd0,   1'b0, 1'b0};
    vecs[3] = '{8'h80,  8'h01, 8'h7F,  1'b0, 1'b1};
    vecs[4] = '{8'h7F,  8'hFF, 8'h80,  1'b1, 1'b1};

    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    tick();
    tick();
    chk("reset_ready", 32'(bus8.ready), 32'd1);
    chk("reset_busy",  32'(bus8.busy),  32'd0);
    chk("reset_done",  32'(bus8.done),  32'd0);
    chk("reset_diff",  32'(bus8.diff),  32'd0);
    chk("reset_bout",  32'(bus8.bout),  32'd0);
    chk("reset_ovf",   32'(bus8.ovf),   32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, d, bo, ov, lat, hs_ok);
      chk($sformatf("vec%0d_diff", i), 32'(d),  32'(vecs[i].diff));
      chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bout));
      chk($sformatf("vec%0d_ovf", i),  32'(ov), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_lat", i),  32'(lat), 32'd8);
      chk($sformatf("vec%0d_hs", i),   32'(hs_ok), 32'd1);
    end

    // Extra start pulses during RUN must be ignored.
    tick();
    bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd3;
    tick();
    bus8.start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      bus8.start = (i == 2 || i == 5);
      bus8.a = 8'hAA; bus8.b = 8'h11;
      tick();
      if (bus8.done) ndone++;
    end
    bus8.start = 1'b0;
    chk("ignored_start_ndone", 32'(ndone), 32'd1);
    chk("ignored_start_diff",  32'(bus8.diff), 32'd6);
    chk("ignored_start_busy",  32'(bus8.busy), 32'd0);

    // Start on the done cycle is accepted; old result held until the new final edge.
    bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd3;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 20 && !bus8.done; i++) tick();
    chk("b2b_first_done", 32'(bus8.done), 32'd1);
    bus8.start = 1'b1; bus8.a = 8'd1; bus8.b = 8'd2;
    tick();
    bus8.start = 1'b0;
    chk("b2b_accept_busy", 32'(bus8.busy), 32'd1);
    chk("b2b_accept_diff", 32'(bus8.diff), 32'd6);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 4) chk("b2b_mid_diff", 32'(bus8.diff), 32'd6);
      if (bus8.done) begin lat = n; break; end
    end
    chk("b2b_lat",  32'(lat), 32'd8);
    chk("b2b_diff", 32'(bus8.diff), 32'hFF);
    chk("b2b_bout", 32'(bus8.bout), 32'd1);

    // Reset on the third RUN edge aborts the operation.
    bus8.start = 1'b1; bus8.a = 8'd200; bus8.b = 8'd50;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  32'(bus8.busy),  32'd0);
    chk("abort_ready", 32'(bus8.ready), 32'd1);
    chk("abort_diff",  32'(bus8.diff),  32'd0);
    chk("abort_bout",  32'(bus8.bout),  32'd0);
    chk("abort_ovf",   32'(bus8.ovf),   32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(1'b0, 8'd200, 8'd50, d, bo, ov, lat, hs_ok);
    chk("after_abort_diff", 32'(d), 32'd150);
    chk("after_abort_lat",  32'(lat), 32'd8);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(8, int'(ra), int'(rb), md, mbo, mov);
      run_op(1'b0, ra, rb, d, bo, ov, lat, hs_ok);
      chk("rand_diff", 32'(d),  32'(md));
      chk("rand_bout", 32'(bo), 32'(mbo));
      chk("rand_ovf",  32'(ov), 32'(mov));
      chk("rand_lat",  32'(lat), 32'd8);
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        model(4, x, y, md, mbo, mov);
        run_op(1'b1, 8'(x), 8'(y), d, bo, ov, lat, hs_ok);
        chk($sformatf("w4_diff_%0d_%0d", x, y), 32'(d),  32'(md));
        chk($sformatf("w4_bout_%0d_%0d", x, y), 32'(bo), 32'(mbo));
        chk($sformatf("w4_ovf_%0d_%0d", x, y),  32'(ov), 32'(mov));
        chk($sformatf("w4_lat_%0d_%0d", x, y),  32'(lat), 32'd4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
